modular_result_stage: RTL

- Final, registered stage of the modular adder/subtractor datapath.
- Consumes the two candidate sums produced by the second stage: w (a+b+s) and v (corrected sum, +1 path), plus the mux borrow bit b4.
- Selects the modular result and buffers it in a small FIFO with valid/ready handshakes on both sides.
- Tracks completed operations for the downstream consumer.

---
 rtl/modular_result_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/modular_result_stage.sv
// Final registered stage of the modular adder/subtractor: selects w or v as the
// residue and buffers {result, sel_v, op} in a small FIFO with valid/ready on both sides.
module modular_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic [WIDTH:0]   w,
    input  logic [WIDTH:0]   v,
    input  logic             b4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel_v,
    output logic             out_op,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic             mem_sel  [DEPTH];
    logic             mem_op   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic [WIDTH-1:0] hold_data;
    logic             hold_sel;
    logic             hold_op;

    logic             push;
    logic             pop;
    logic             sel_v;
    logic [WIDTH-1:0] sel_data;
    logic             unused_w_carry;

    // Readiness depends only on registered occupancy, so a full FIFO never pushes on a pop edge.
    assign in_ready  = (occ != FULL_OCC);
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A carry out of v or a borrow from the mux means the corrected sum is the residue.
    assign sel_v          = v[WIDTH] | b4;
    assign sel_data       = sel_v ? v[WIDTH-1:0] : w[WIDTH-1:0];
    assign unused_w_carry = w[WIDTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sel_data;
            mem_sel[wr_ptr]  <= sel_v;
            mem_op[wr_ptr]   <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    // The popped head is kept so the outputs hold their last value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            hold_data <= '0;
            hold_sel  <= 1'b0;
            hold_op   <= 1'b0;
        end else if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            hold_data <= mem_data[rd_ptr];
            hold_sel  <= mem_sel[rd_ptr];
            hold_op   <= mem_op[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (pop) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

    assign out_data  = out_valid ? mem_data[rd_ptr] : hold_data;
    assign out_sel_v = out_valid ? mem_sel[rd_ptr]  : hold_sel;
    assign out_op    = out_valid ? mem_op[rd_ptr]   : hold_op;

endmodule
